mem_stage_ls: RTL and testbench

Parametrised memory-access stage for the five-stage pipeline, sitting between EXE and WB. It accepts the EXE result bus and waits on the data SRAM response when EXE issued a load/store request. It performs byte/half/word(/double) load extraction with sign or zero extension, and holds early-returning read data in a one-entry buffer while WB is stalled. On a pipeline flush it drops in-flight responses, and it exports forwarding and load-use information to ID.

---
 rtl/mem_stage_ls.sv | 78 +++++++
 tb/tb_mem_stage_ls.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ls.sv
// mem_stage_ls: MEM pipeline stage with load extraction, one-entry response buffer, flush discard and forwarding
module mem_stage_ls #(
  parameter int XLEN = 32,
  localparam int OFS_W = $clog2(XLEN/8),
  localparam int EM_W = 43 + 2*XLEN,
  localparam int MW_W = 38 + 2*XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exe_mem_valid,
  output logic            mem_allowin,
  input  logic [EM_W-1:0] exe_mem_bus,
  output logic            mem_wb_valid,
  input  logic            wb_allowin,
  output logic [MW_W-1:0] mem_wb_bus,
  input  logic            data_sram_data_ok,
  input  logic [XLEN-1:0] data_sram_rdata,
  input  logic            mem_flush,
  output logic            mem_fwd_we,
  output logic [4:0]      mem_fwd_dest,
  output logic [XLEN-1:0] mem_fwd_data,
  output logic            mem_ld_pending
);
  logic mem_valid, buf_valid, ok_cur, ready_go, leave, inc, dec;
  logic [EM_W-1:0] bus_r;
  logic [XLEN-1:0] rdata_buf, rdata_eff, extracted, final_result, pc, alu_result;
  logic [1:0] discard_cnt;
  logic gr_we, res_from_mem, mem_req;
  logic [2:0] ld_op;
  logic [4:0] dest;
  logic [31:0] inst, w;
  logic [OFS_W-1:0] o;
  logic [15:0] h;
  logic [7:0] b;
  assign {gr_we, res_from_mem, mem_req, ld_op, dest, pc, inst, alu_result} = bus_r;
  assign ok_cur = data_sram_data_ok & (discard_cnt == 2'd0);
  assign ready_go = ~mem_req | ok_cur | buf_valid;
  assign leave = mem_valid & ready_go & wb_allowin;
  assign mem_wb_valid = mem_valid & ready_go & ~mem_flush;
  assign mem_allowin = ~mem_valid | (ready_go & wb_allowin) | mem_flush;
  assign rdata_eff = buf_valid ? rdata_buf : data_sram_rdata;
  assign o = alu_result[OFS_W-1:0];
  assign b = 8'(rdata_eff >> {o, 3'b0});
  assign h = 16'(rdata_eff >> {o[OFS_W-1:1], 4'b0});
  assign w = 32'(rdata_eff >> {o >> 2, 5'b0});
  always_comb begin
    extracted = (ld_op == 3'b000) ? XLEN'($signed(b)) :
                (ld_op == 3'b100) ? XLEN'(b) :
                (ld_op == 3'b001) ? XLEN'($signed(h)) :
                (ld_op == 3'b101) ? XLEN'(h) :
                (ld_op == 3'b010) ? XLEN'($signed(w)) :
                (ld_op == 3'b110 && XLEN == 64) ? XLEN'(w) : rdata_eff;
    final_result = res_from_mem ? extracted : alu_result;
  end
  assign mem_wb_bus = {gr_we, pc, inst, final_result, dest};
  assign mem_fwd_we = mem_valid & gr_we & ready_go;
  assign mem_fwd_dest = dest;
  assign mem_fwd_data = final_result;
  assign mem_ld_pending = mem_valid & res_from_mem & ~ready_go;
  // a killed request whose response is still outstanding must have that response swallowed later
  assign inc = mem_flush & mem_valid & mem_req & ~ok_cur & ~buf_valid;
  assign dec = data_sram_data_ok & (discard_cnt != 2'd0);
  always_ff @(posedge clk) begin
    if (mem_allowin & exe_mem_valid & ~mem_flush) bus_r <= exe_mem_bus;
    if (mem_valid & mem_req & ok_cur & ~buf_valid) rdata_buf <= data_sram_rdata;
    if (reset) begin
      mem_valid <= 1'b0;
      buf_valid <= 1'b0;
      discard_cnt <= 2'd0;
    end else begin
      if (mem_allowin) mem_valid <= exe_mem_valid & ~mem_flush;
      if (mem_flush | leave) buf_valid <= 1'b0;
      else if (mem_valid & mem_req & ok_cur) buf_valid <= 1'b1;
      discard_cnt <= (inc & ~dec & (discard_cnt != 2'd3)) ? discard_cnt + 2'd1 :
                     (dec & ~inc) ? discard_cnt - 2'd1 : discard_cnt;
    end
  end
endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: scoreboard bench for mem_stage_ls at XLEN=32 and XLEN=64
module tb_mem_stage_ls;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic sel = 0, vld = 0, ok = 0, flush = 0, wb_allowin = 1;
  logic gw = 0, rfm = 0, req = 0;
  logic [2:0] op = 0;
  logic [4:0] dst = 0;
  logic [63:0] alu = 0, rdata = 0;
  int n_chk = 0, n_fail = 0;
  logic [68:0] q32[$], q64[$];
  logic [68:0] e32, e64;
  logic [106:0] bus32;
  logic [170:0] bus64;
  logic [101:0] wbbus32;
  logic [165:0] wbbus64;
  logic allow32, wbv32, fwe32, pend32, allow64, wbv64, fwe64, pend64;
  logic [4:0] fdst32, fdst64;
  logic [31:0] fdata32;
  logic [63:0] fdata64;
  logic allow_c, wbv_c, fwe_c, pend_c;
  logic [63:0] fdata_c;
  logic [4:0] fdst_c;
  assign bus32 = {gw, rfm, req, op, dst, 32'h1c00_0100, 32'h2880_0000, alu[31:0]};
  assign bus64 = {gw, rfm, req, op, dst, 64'h1c00_0200, 32'h2880_0000, alu};
  assign allow_c = sel ? allow64 : allow32;
  assign wbv_c = sel ? wbv64 : wbv32;
  assign fwe_c = sel ? fwe64 : fwe32;
  assign pend_c = sel ? pend64 : pend32;
  assign fdata_c = sel ? fdata64 : {32'b0, fdata32};
  assign fdst_c = sel ? fdst64 : fdst32;

  mem_stage_ls #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .exe_mem_valid(vld & ~sel), .mem_allowin(allow32),
    .exe_mem_bus(bus32), .mem_wb_valid(wbv32), .wb_allowin(wb_allowin), .mem_wb_bus(wbbus32),
    .data_sram_data_ok(ok & ~sel), .data_sram_rdata(rdata[31:0]), .mem_flush(flush & ~sel),
    .mem_fwd_we(fwe32), .mem_fwd_dest(fdst32), .mem_fwd_data(fdata32), .mem_ld_pending(pend32));

  mem_stage_ls #(.XLEN(64)) u64 (
    .clk(clk), .reset(reset), .exe_mem_valid(vld & sel), .mem_allowin(allow64),
    .exe_mem_bus(bus64), .mem_wb_valid(wbv64), .wb_allowin(wb_allowin), .mem_wb_bus(wbbus64),
    .data_sram_data_ok(ok & sel), .data_sram_rdata(rdata), .mem_flush(flush & sel),
    .mem_fwd_we(fwe64), .mem_fwd_dest(fdst64), .mem_fwd_data(fdata64), .mem_ld_pending(pend64));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!reset && wbv32 && wb_allowin) begin
    if (q32.size() == 0) chk("mon32_unexpected", 64'(wbbus32[36:5]), 64'hxxxx_xxxx_xxxx_xxxx);
    else begin
      e32 = q32.pop_front();
      chk("mon32_result", 64'(wbbus32[36:5]), e32[63:0]);
      chk("mon32_dest", 64'(wbbus32[4:0]), 64'(e32[68:64]));
    end
  end

  always @(negedge clk) if (!reset && wbv64 && wb_allowin) begin
    if (q64.size() == 0) chk("mon64_unexpected", wbbus64[68:5], 64'hxxxx_xxxx_xxxx_xxxx);
    else begin
      e64 = q64.pop_front();
      chk("mon64_result", wbbus64[68:5], e64[63:0]);
      chk("mon64_dest", 64'(wbbus64[4:0]), 64'(e64[68:64]));
    end
  end

  task automatic push(input logic [4:0] d, input logic [63:0] v);
    if (sel) q64.push_back({d, v});
    else q32.push_back({d, v});
  endtask

  task automatic issue(input logic g, input logic f, input logic r, input logic [2:0] o,
                       input logic [4:0] d, input logic [63:0] a);
    int t = 0;
    gw = g; rfm = f; req = r; op = o; dst = d; alu = a; vld = 1;
    @(negedge clk);
    while (!allow_c && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("issue_allowin", 64'(allow_c), 64'd1);
    @(posedge clk); #1;
    vld = 0;
  endtask

  task automatic load(input logic [2:0] o, input logic [63:0] a, input logic [4:0] d,
                      input logic [63:0] exp, input int lat, input logic [63:0] rd, input logic f = 1);
    push(d, exp);
    issue(1, f, 1, o, d, a);
    repeat (lat) begin
      @(negedge clk);
      chk("ld_pending", 64'(pend_c), 64'(f));
      @(posedge clk); #1;
    end
    ok = 1; rdata = rd;
    @(posedge clk); #1;
    ok = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_allowin32", 64'(allow32), 64'd1);
    chk("rst_wbv32", 64'(wbv32), 64'd0);
    chk("rst_fwe32", 64'(fwe32), 64'd0);
    chk("rst_pend32", 64'(pend32), 64'd0);
    chk("rst_allowin64", 64'(allow64), 64'd1);
    chk("rst_wbv64", 64'(wbv64), 64'd0);
    @(posedge clk); #1;
    push(5'd1, 64'h1234);
    issue(1, 0, 0, 3'b000, 5'd1, 64'h1234);
    @(negedge clk);
    chk("alu_fwd_we", 64'(fwe_c), 64'd1);
    chk("alu_fwd_data", fdata_c, 64'h1234);
    chk("alu_fwd_dest", 64'(fdst_c), 64'd1);
    @(posedge clk); #1;
    load(3'b000, 64'h1003, 5'd2, 64'hFFFF_FF80, 2, 64'h80FF_0000);
    load(3'b100, 64'h1003, 5'd3, 64'h0000_0080, 0, 64'h80FF_0000);
    load(3'b101, 64'h1002, 5'd4, 64'h0000_80FF, 1, 64'h80FF_0000);
    load(3'b001, 64'h1002, 5'd5, 64'hFFFF_80FF, 0, 64'h80FF_0000);
    load(3'b000, 64'h1001, 5'd6, 64'h0000_0056, 0, 64'h1234_5678);
    load(3'b010, 64'h1000, 5'd8, 64'h9ABC_DEF0, 0, 64'h9ABC_DEF0);
    load(3'b010, 64'h0044, 5'd9, 64'h0000_0044, 1, 64'h5555_5555, 0);
    load(3'b111, 64'h1001, 5'd10, 64'h8765_4321, 0, 64'h8765_4321);
    load(3'b110, 64'h1000, 5'd11, 64'h0BAD_F00D, 0, 64'h0BAD_F00D);
    push(5'd7, 64'hCAFE_BABE);
    issue(1, 1, 1, 3'b010, 5'd7, 64'h2000);
    wb_allowin = 0; ok = 1; rdata = 64'hCAFE_BABE;
    @(negedge clk);
    chk("buf_wbv", 64'(wbv_c), 64'd1);
    chk("buf_allowin", 64'(allow_c), 64'd0);
    @(posedge clk); #1;
    ok = 0; rdata = 0;
    repeat (2) begin
      @(negedge clk);
      chk("buf_hold_wbv", 64'(wbv_c), 64'd1);
      chk("buf_hold_pend", 64'(pend_c), 64'd0);
      chk("buf_hold_data", fdata_c, 64'hCAFE_BABE);
      @(posedge clk); #1;
    end
    wb_allowin = 1;
    @(posedge clk); #1;
    issue(1, 1, 1, 3'b010, 5'd12, 64'h3000);
    flush = 1;
    @(negedge clk);
    chk("flush_wbv", 64'(wbv_c), 64'd0);
    chk("flush_allowin", 64'(allow_c), 64'd1);
    @(posedge clk); #1;
    flush = 0;
    push(5'd13, 64'h2);
    issue(1, 1, 1, 3'b010, 5'd13, 64'h3004);
    ok = 1; rdata = 64'h1;
    @(negedge clk);
    chk("discard_pend", 64'(pend_c), 64'd1);
    chk("discard_wbv", 64'(wbv_c), 64'd0);
    @(posedge clk); #1;
    rdata = 64'h2;
    @(posedge clk); #1;
    ok = 0;
    issue(1, 1, 1, 3'b010, 5'd14, 64'h4000);
    flush = 1; ok = 1; rdata = 64'hDEAD;
    @(negedge clk);
    chk("flush_ok_wbv", 64'(wbv_c), 64'd0);
    @(posedge clk); #1;
    flush = 0; ok = 0;
    load(3'b010, 64'h4004, 5'd15, 64'h55, 0, 64'h55);
    sel = 1;
    push(5'd16, 64'h1_2345_6789);
    issue(1, 0, 0, 3'b000, 5'd16, 64'h1_2345_6789);
    load(3'b110, 64'h4, 5'd17, 64'h0000_0000_8000_0001, 1, 64'h8000_0001_0000_0000);
    load(3'b010, 64'h4, 5'd18, 64'hFFFF_FFFF_8000_0001, 0, 64'h8000_0001_0000_0000);
    load(3'b010, 64'h0, 5'd19, 64'h0000_0000_7333_4444, 0, 64'h1111_2222_7333_4444);
    load(3'b000, 64'h7, 5'd20, 64'hFFFF_FFFF_FFFF_FF80, 0, 64'h8000_0001_0000_0000);
    load(3'b101, 64'h2, 5'd21, 64'h0000_0000_0000_7333, 0, 64'h1111_2222_7333_4444);
    load(3'b011, 64'h0, 5'd22, 64'h8000_0001_0000_0000, 2, 64'h8000_0001_0000_0000);
    for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain_q32", 64'(q32.size()), 64'd0);
    chk("drain_q64", 64'(q64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
